muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers, sitting beside the EX-stage ALU. It takes the same operand buses and executes MULT/MULTU/DIV/DIVU over multiple cycles, plus single-cycle MTHI/MTLO writes. HI/LO feed MFHI/MFLO forwarding to the EX/MEM stage. While an operation is in flight, busy stalls the issue stage.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  issue request; sampled only when busy=0
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others = no-op
a  input  WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO source)
b  input  WIDTH  rt operand (multiplier/divisor)
flush  input  1  abort in-flight op (exception/branch squash)
busy  output  1  op in flight; issue stage must stall MFHI/MFLO and new starts
done  output  1  one-cycle pulse when HI/LO receive a MULT/DIV result
div_by_zero  output  1  one-cycle pulse, coincident with done, for DIV/DIVU with b=0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (rst_n=0, async): state IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0; iteration counter and datapath registers cleared. Reset mid-operation discards all work.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE + start + MULT/MULTU: latch |a|, |b| (raw for MULTU), result sign = a[MSB]^b[MSB] (0 for MULTU). Go to MUL, busy=1.
- MUL: radix-2 shift-add on magnitudes, one bit per cycle, WIDTH cycles, then FIX.
- IDLE + start + DIV/DIVU with b!=0: latch magnitudes. Quotient sign = a^b sign; remainder sign = a sign (unsigned: both 0). Go to DIV.
- DIV: restoring division, one quotient bit per cycle, WIDTH cycles, then FIX.
- FIX (one cycle): apply two's-complement negation per the latched signs.
  - Multiply writes {hi,lo} = 2*WIDTH-bit product.
  - Divide writes lo = quotient, hi = remainder.
  - Pulse done; return to IDLE with busy=0.
- Latency: start accepted at edge 0 → hi/lo updated and done=1 after edge WIDTH+1 (33 for WIDTH=32). busy=1 from edge 0 until edge WIDTH+1, when it clears.
- Divide by zero: start at edge 0 → after edge 1: hi=a, lo=all ones, done=1, div_by_zero=1, busy low again. No iterations run.
- DIV of most-negative by -1: lo=0x80000000, hi=0. No trap.
- MTHI/MTLO in IDLE: hi (or lo) = a at the next edge. busy stays 0; done stays 0.
- start while busy=1: ignored, including MTHI/MTLO.
- Undefined op codes: no state change.
- flush while busy: at the next edge, return to IDLE with busy=0 and no done. hi/lo keep their pre-operation values.
  - flush in IDLE has no effect.
  - flush and start in the same IDLE cycle: flush wins and the start is dropped.
- hi/lo are registered outputs, stable except on a FIX write, a div-by-zero write, or an MTHI/MTLO write.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 → after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFF1; done high exactly one cycle; busy high 33 cycles.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Same operands with MULT → hi=0, lo=1.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 → after 1 cycle hi=0x1234, lo=0xFFFFFFFF, done=div_by_zero=1 for one cycle.
- MTHI a=0xDEADBEEF, then a MULT start while busy followed by a second start with a new op → second start ignored. flush asserted at iteration 10 → busy drops next cycle, no done, hi=0xDEADBEEF.
- rst_n pulsed low at iteration 20 of a DIVU → hi=lo=0 and busy=0 immediately (asynchronous). A new MULT started after reset completes correctly.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on magnitudes, sign fix-up in a final cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int W2 = 2 * WIDTH;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;   // multiplicand or divisor magnitude
  logic [W2-1:0]    acc_q, acc_d;       // {product hi, multiplier} or {remainder, quotient}
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             is_div_q, is_div_d;
  logic             dz_pend_q, dz_pend_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic             signed_op;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next;
  logic [WIDTH:0]   rem_sh, div_diff;
  logic             qbit;
  logic [W2-1:0]    div_next;
  logic             cnt_last;

  assign signed_op = ~op[0];
  assign abs_a     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign abs_b     = (signed_op && b[WIDTH-1]) ? -b : b;

  assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  assign rem_sh   = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = rem_sh - {1'b0, mcand_q};
  assign qbit     = ~div_diff[WIDTH];
  assign div_next = {(qbit ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], qbit};

  assign cnt_last = (cnt_q == CW'(WIDTH - 1));

  // NOTE: every variable gets its default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    is_div_d  = is_div_q;
    dz_pend_d = dz_pend_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              acc_d    = {{WIDTH{1'b0}}, abs_a};
              mcand_d  = abs_b;
              neg_lo_d = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_hi_d = 1'b0;
              is_div_d = 1'b0;
              cnt_d    = '0;
              state_d  = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              is_div_d = 1'b1;
              cnt_d    = '0;
              if (b == '0) begin
                // Divide by zero skips iterations: FIX copies acc straight to HI/LO.
                acc_d     = {a, {WIDTH{1'b1}}};
                neg_lo_d  = 1'b0;
                neg_hi_d  = 1'b0;
                dz_pend_d = 1'b1;
                state_d   = S_FIX;
              end else begin
                acc_d     = {{WIDTH{1'b0}}, abs_a};
                mcand_d   = abs_b;
                neg_lo_d  = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_hi_d  = signed_op & a[WIDTH-1];
                dz_pend_d = 1'b0;
                state_d   = S_DIV;
              end
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_last) state_d = S_FIX;
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_last) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = neg_hi_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
          lo_d = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        end else begin
          {hi_d, lo_d} = neg_lo_q ? -acc_q : acc_q;
        end
        done_d    = 1'b1;
        dz_d      = dz_pend_q;
        dz_pend_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      dz_d      = 1'b0;
      dz_pend_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      is_div_q  <= 1'b0;
      dz_pend_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      neg_lo_q  <= neg_lo_d;
      neg_hi_q  <= neg_hi_d;
      is_div_q  <= is_div_d;
      dz_pend_q <= dz_pend_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random ops against an arithmetic model.
module tb_muldiv_unit;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [2:0]       op = 3'b111;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             flush = 1'b0;
  logic             busy, done, div_by_zero;
  logic [WIDTH-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference results from plain 64-bit arithmetic.
  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el, output logic edz);
    longint sx, sy, q, r;
    logic [63:0] p;
    edz = 1'b0;
    eh = '0;
    el = '0;
    sx = o[0] ? longint'({32'b0, x}) : longint'($signed(x));
    sy = o[0] ? longint'({32'b0, y}) : longint'($signed(y));
    if (o == 3'b001) begin
      p = {32'b0, x} * {32'b0, y};
      {eh, el} = p;
    end else if (o == 3'b000) begin
      p = 64'(sx * sy);
      {eh, el} = p;
    end else if (y == 32'b0) begin
      eh = x;
      el = '1;
      edz = 1'b1;
    end else begin
      q = sx / sy;
      r = sx % sy;
      el = q[31:0];
      eh = r[31:0];
    end
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] eh, el, h0, l0;
    logic edz;
    int n, busy_n, exp_lat;
    bit moved;
    model(o, x, y, eh, el, edz);
    exp_lat = edz ? 1 : LAT;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    h0 = hi; l0 = lo;
    @(negedge clk);
    start = 1'b0; op = 3'b111; a = $urandom; b = $urandom;
    n = 0; busy_n = 0; moved = 0;
    while (!done && n < 100) begin
      if (busy) busy_n++;
      if (hi !== h0 || lo !== l0) moved = 1;
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), 64'(exp_lat));
    check("busy_cycles", 64'(busy_n), 64'(exp_lat));
    check("hold_during_op", 64'(moved), 64'd0);
    check("busy_clear", 64'(busy), 64'd0);
    check("hi", 64'(hi), 64'(eh));
    check("lo", 64'(lo), 64'(el));
    check("div_by_zero", 64'(div_by_zero), 64'(edz));
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    check("dz_one_cycle", 64'(div_by_zero), 64'd0);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 3'b111;
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] x, y, eh, el;
    logic        edz;
    int          n, done_seen;

    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'b000, 32'hFFFF_FFFD, 32'd5);
    check("mult_neg3x5_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    check("mult_neg3x5_lo", 64'(lo), 64'h0000_0000_FFFF_FFF1);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2);
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_minneg_lo", 64'(lo), 64'h0000_0000_8000_0000);
    run_op(3'b011, 32'h0000_1234, 32'd0);
    run_op(3'b010, 32'hFFFF_FF00, 32'd0);
    run_op(3'b011, 32'hFFFF_FFFF, 32'd1);

    issue(3'b100, 32'hDEAD_BEEF, 32'd0);
    check("mthi_hi", 64'(hi), 64'h0000_0000_DEAD_BEEF);
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_done", 64'(done), 64'd0);
    issue(3'b101, 32'h0000_0055, 32'd0);
    check("mtlo_lo", 64'(lo), 64'h0000_0000_0000_0055);
    check("mtlo_hi_kept", 64'(hi), 64'h0000_0000_DEAD_BEEF);

    issue(3'b110, 32'h1111_1111, 32'h2222_2222);
    check("undef_busy", 64'(busy), 64'd0);
    check("undef_hi", 64'(hi), 64'h0000_0000_DEAD_BEEF);
    check("undef_lo", 64'(lo), 64'h0000_0000_0000_0055);

    // Starts while busy must be ignored, including MTLO.
    issue(3'b000, 32'd7, 32'hFFFF_FFFA);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd3;
    @(negedge clk);
    op = 3'b101; a = 32'h7777_7777;
    @(negedge clk);
    start = 1'b0; op = 3'b111;
    n = 5;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("busy_start_latency", 64'(n), 64'(LAT));
    check("busy_start_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    check("busy_start_lo", 64'(lo), 64'h0000_0000_FFFF_FFD6);

    // Flush mid-operation keeps pre-op HI/LO and produces no done.
    issue(3'b100, 32'hDEAD_BEEF, 32'd0);
    issue(3'b101, 32'h0000_0055, 32'd0);
    issue(3'b000, 32'h1234_5678, 32'h0000_0099);
    repeat (9) @(negedge clk);
    check("pre_flush_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_done", 64'(done), 64'd0);
    check("flush_hi", 64'(hi), 64'h0000_0000_DEAD_BEEF);
    check("flush_lo", 64'(lo), 64'h0000_0000_0000_0055);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("flush_no_late_done", 64'(done_seen), 64'd0);

    // Flush and start together in IDLE: flush wins.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'b100; a = 32'h0000_0001;
    @(negedge clk);
    op = 3'b000; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0; op = 3'b111;
    check("idle_flush_hi", 64'(hi), 64'h0000_0000_DEAD_BEEF);
    check("idle_flush_busy", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of a divide.
    issue(3'b011, 32'd1000, 32'd7);
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_hi", 64'(hi), 64'd0);
    check("async_rst_lo", 64'(lo), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'b000, 32'hFFFF_FFFD, 32'd5);

    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: x = 32'h8000_0000;
        1: y = 32'hFFFF_FFFF;
        2: y = 32'd0;
        3: y = 32'($urandom_range(1, 20));
        default: ;
      endcase
      run_op(o, x, y);
    end

    model(3'b010, 32'd17, 32'd5, eh, el, edz);
    run_op(3'b010, 32'd17, 32'd5);
    check("final_div_lo", 64'(lo), 64'd3);
    check("final_div_hi", 64'(hi), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
